// File: rtl/conv_window_ctrl.sv
// Sequences a 3x3 convolution over a feature map: fetches each patch, hands it to the conv unit, writes the result.
// Optional macro CONV_ZERO_PAD_EN selects same-padding (zero taps outside the image) instead of valid convolution.
module conv_window_ctrl #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 16,
    parameter int unsigned CONV_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     img_w,
    input  logic [AW-1:0]     img_h,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [DW-1:0]     rd_data,
    output logic [9*DW-1:0]   patch_flat,
    output logic              patch_valid,
    input  logic [DW-1:0]     conv_result,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [AW-1:0]     wr_addr,
    output logic [DW-1:0]     wr_data
);

`ifdef CONV_ZERO_PAD_EN
    localparam int unsigned OFF = 1;
`else
    localparam int unsigned OFF = 0;
`endif
    localparam int unsigned TAPS = 9;
    localparam int unsigned LW   = (CONV_LAT < 2) ? 1 : $clog2(CONV_LAT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, CONV, WRITE, DONE} state_t;

    state_t          state;
    logic [AW-1:0]   w_q, h_q, ow_q, oh_q;
    logic [AW-1:0]   ox, oy;
    logic [3:0]      tap_cnt;
    logic [LW-1:0]   lat_cnt;
    logic            rd_en_q;

    logic [AW-1:0]   ow_c, oh_c;
    logic            empty_c;
    logic            last_x_c, last_c;
    logic [AW-1:0]   nx_c, ny_c;

    // Output frame size from the requested input size
    always_comb begin
`ifdef CONV_ZERO_PAD_EN
        ow_c    = img_w;
        oh_c    = img_h;
        empty_c = (img_w == '0) || (img_h == '0);
`else
        ow_c    = img_w - AW'(2);
        oh_c    = img_h - AW'(2);
        empty_c = (img_w < AW'(3)) || (img_h < AW'(3));
`endif
    end

    // Row-major advance of the output pixel position
    always_comb begin
        last_x_c = (ox == ow_q - AW'(1));
        last_c   = last_x_c && (oy == oh_q - AW'(1));
        nx_c     = last_x_c ? '0 : ox + AW'(1);
        ny_c     = last_x_c ? oy + AW'(1) : oy;
    end

    // {in_bounds, address} of tap (ky*3+kx) for output pixel (cx, cy)
    function automatic logic [AW:0] tap_fn(input logic [3:0]    tap,
                                           input logic [AW-1:0] cx,
                                           input logic [AW-1:0] cy,
                                           input logic [AW-1:0] w,
                                           input logic [AW-1:0] h);
        logic [1:0]            kx, ky;
        logic signed [AW+1:0]  xs, ys;
        logic                  en;
        ky = (tap >= 4'd6) ? 2'd2 : ((tap >= 4'd3) ? 2'd1 : 2'd0);
        kx = 2'(tap - 4'(ky) * 4'd3);
        xs = $signed({2'b00, cx}) + $signed({{AW{1'b0}}, kx}) - $signed((AW+2)'(OFF));
        ys = $signed({2'b00, cy}) + $signed({{AW{1'b0}}, ky}) - $signed((AW+2)'(OFF));
        en = !xs[AW+1] && !ys[AW+1] &&
             (xs < $signed({2'b00, w})) && (ys < $signed({2'b00, h}));
        return {en, en ? AW'((2*AW)'(ys[AW-1:0]) * (2*AW)'(w)) + xs[AW-1:0] : AW'(0)};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            patch_flat  <= '0;
            patch_valid <= 1'b0;
            wr_valid    <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            w_q         <= '0;
            h_q         <= '0;
            ow_q        <= '0;
            oh_q        <= '0;
            ox          <= '0;
            oy          <= '0;
            tap_cnt     <= '0;
            lat_cnt     <= '0;
            rd_en_q     <= 1'b0;
        end else begin
            done        <= 1'b0;
            patch_valid <= 1'b0;
            rd_en_q     <= rd_en;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        w_q     <= img_w;
                        h_q     <= img_h;
                        ow_q    <= ow_c;
                        oh_q    <= oh_c;
                        ox      <= '0;
                        oy      <= '0;
                        tap_cnt <= '0;
                        busy    <= 1'b1;
                        if (empty_c) begin
                            state <= DONE;
                        end else begin
                            {rd_en, rd_addr} <= tap_fn(4'd0, '0, '0, img_w, img_h);
                            state            <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    // Read data lags its strobe by one cycle; skipped taps load zero
                    for (int k = 0; k < TAPS; k++) begin
                        if (tap_cnt == 4'(k + 1)) begin
                            patch_flat[k*DW +: DW] <= rd_en_q ? rd_data : '0;
                        end
                    end
                    if (tap_cnt < 4'd8) begin
                        {rd_en, rd_addr} <= tap_fn(tap_cnt + 4'd1, ox, oy, w_q, h_q);
                    end else begin
                        rd_en <= 1'b0;
                    end
                    if (tap_cnt == 4'(TAPS)) begin
                        state       <= CONV;
                        patch_valid <= 1'b1;
                        lat_cnt     <= '0;
                    end else begin
                        tap_cnt <= tap_cnt + 4'd1;
                    end
                end
                CONV: begin
                    if (lat_cnt == LW'(CONV_LAT)) begin
                        wr_data  <= conv_result;
                        wr_addr  <= AW'((2*AW)'(oy) * (2*AW)'(ow_q)) + ox;
                        wr_valid <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                WRITE: begin
                    if (wr_ready) begin
                        wr_valid <= 1'b0;
                        if (last_c) begin
                            state <= DONE;
                        end else begin
                            ox               <= nx_c;
                            oy               <= ny_c;
                            tap_cnt          <= '0;
                            {rd_en, rd_addr} <= tap_fn(4'd0, nx_c, ny_c, w_q, h_q);
                            state            <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl: RAM and conv-unit models plus a direct convolution reference.
module tb_conv_window_ctrl;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
`ifdef CONV_ZERO_PAD_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   img_w = '0, img_h = '0;
    logic            busy, done, rd_en, patch_valid, wr_valid;
    logic            wr_ready = 1'b0;
    logic [AW-1:0]   rd_addr, wr_addr;
    logic [DW-1:0]   rd_data = '0, conv_result = '0, wr_data;
    logic [9*DW-1:0] patch_flat;

    always #5 clk = ~clk;

    conv_window_ctrl #(.DW(DW), .AW(AW), .CONV_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .img_w(img_w), .img_h(img_h),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .patch_flat(patch_flat), .patch_valid(patch_valid), .conv_result(conv_result),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    int img [256];
    int passed = 0, total = 0;

    function automatic int wt(input int kx, input int ky);
        return ((kx == 1) ? 2 : 1) * ((ky == 1) ? 2 : 1);
    endfunction

    // Conv unit: one register stage, ReLU on output
    function automatic logic [DW-1:0] conv_fn(input logic [9*DW-1:0] p);
        longint s;
        s = 0;
        for (int k = 0; k < 9; k++)
            s += longint'(wt(k % 3, k / 3)) * longint'($signed(p[k*DW +: DW]));
        return (s < 0) ? '0 : DW'(s);
    endfunction

    // Reference: direct convolution of the image array at output pixel (ox, oy)
    function automatic longint exp_pix(input int ox, input int oy, input int w, input int h);
        longint s;
        int x, y;
        s = 0;
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                x = ox + kx - OFF;
                y = oy + ky - OFF;
                if (x >= 0 && x < w && y >= 0 && y < h) s += longint'(wt(kx, ky) * img[y*w + x]);
            end
        return (s < 0) ? 0 : s;
    endfunction

    always @(posedge clk) begin
        if (rd_en) rd_data <= img[rd_addr[7:0]];
        if (patch_valid) conv_result <= conv_fn(patch_flat);
    end

    // Output buffer: holds wr_ready low for bp_cycles of each write, else ready
    int bp_cycles = 0;
    int stall_cnt = 0;
    always @(negedge clk) begin
        if (wr_valid && stall_cnt < bp_cycles) begin
            wr_ready = 1'b0;
            stall_cnt++;
        end else begin
            wr_ready = (bp_cycles == 0) || wr_valid;
            if (!wr_valid) stall_cnt = 0;
        end
    end

    logic [AW-1:0] rd_q [$];
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            done_cnt = 0;
    int            unstable = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_data = '0;

    always @(posedge clk) begin
        if (rd_en) rd_q.push_back(rd_addr);
        if (wr_valid && wr_ready) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (rst_n && prev_stall && (wr_valid !== 1'b1 || wr_addr !== p_addr || wr_data !== p_data))
            unstable <= unstable + 1;
        prev_stall <= rst_n && wr_valid && !wr_ready;
        p_addr     <= wr_addr;
        p_data     <= wr_data;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic pulse_start(input int w, input int h);
        @(negedge clk);
        img_w = AW'(w);
        img_h = AW'(h);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int w, input int h, input int bp, input bit restart);
        int ow, oh, rb, wb, db, cyc, bad, nw, nr, x, y;
        int exp_rd [$];
        ow = (OFF == 1) ? w : w - 2;
        oh = (OFF == 1) ? h : h - 2;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        x = ox + kx - OFF;
                        y = oy + ky - OFF;
                        if (x >= 0 && x < w && y >= 0 && y < h) exp_rd.push_back(y*w + x);
                    end
        rb = rd_q.size();
        wb = wa_q.size();
        db = done_cnt;
        bp_cycles = bp;
        pulse_start(w, h);
        check({tag, "_busy"}, 64'(busy), 64'(1));
        cyc = 0;
        while (done_cnt == db && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (restart && cyc == 20) begin
                img_w = AW'(8);
                img_h = AW'(8);
                start = 1'b1;
            end else if (cyc == 21) begin
                start = 1'b0;
            end
        end
        check({tag, "_done"}, 64'(done_cnt - db), 64'(1));
        if (bp == 0 && !restart) check({tag, "_latency"}, 64'(cyc), 64'(13*ow*oh + 2));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        repeat (3) @(negedge clk);
        check({tag, "_one_done"}, 64'(done_cnt - db), 64'(1));
        nw = wa_q.size() - wb;
        check({tag, "_nwrites"}, 64'(nw), 64'(ow*oh));
        for (int i = 0; i < nw && i < ow*oh; i++) begin
            check({tag, "_waddr"}, 64'(wa_q[wb+i]), 64'(i));
            check({tag, "_wdata"}, 64'(wd_q[wb+i]), 64'(exp_pix(i % ow, i / ow, w, h)));
        end
        nr = rd_q.size() - rb;
        check({tag, "_nreads"}, 64'(nr), 64'(exp_rd.size()));
        bad = 0;
        for (int i = 0; i < nr && i < exp_rd.size(); i++)
            if (rd_q[rb+i] !== AW'(exp_rd[i])) bad++;
        check({tag, "_rd_seq_bad"}, 64'(bad), 64'(0));
        check({tag, "_stall_stable_bad"}, 64'(unstable), 64'(0));
    endtask

    task automatic fill_const(input int n, input int v);
        for (int i = 0; i < n; i++) img[i] = v;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) img[i] = int'($urandom_range(200)) - 100;
    endtask

    initial begin
        int wb, rb, db, cyc, ew;
        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({busy, done, rd_en, wr_valid, patch_valid}), 64'(0));
        check("rst_data", 64'({rd_addr, wr_addr, wr_data}), 64'(0));
        check("rst_patch", 64'(|patch_flat), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        fill_const(16, 1);
        run_frame("t1_ones4x4", 4, 4, 0, 1'b0);

        for (int i = 0; i < 9; i++) img[i] = i;
        run_frame("t2_ramp3x3", 3, 3, 0, 1'b0);

`ifdef CONV_ZERO_PAD_EN
        fill_const(9, 1);
        run_frame("t3_pad_ones3x3", 3, 3, 0, 1'b0);
`endif

        fill_const(16, 1);
        run_frame("t4_backpressure", 4, 4, 5, 1'b0);

        fill_rand(16);
        run_frame("t5_restart_ignored", 4, 4, 0, 1'b1);

        for (int t = 0; t < 3; t++) begin
            int w, h;
            w = int'($urandom_range(6, 3));
            h = int'($urandom_range(6, 3));
            fill_rand(w*h);
            run_frame("rand_frame", w, h, int'($urandom_range(3)), 1'b0);
        end

        // Reset while the third output pixel is stalled in its write
        fill_rand(16);
        bp_cycles = 5;
        wb = wa_q.size();
        db = done_cnt;
        pulse_start(4, 4);
        cyc = 0;
        while (!((wa_q.size() - wb) == 2 && wr_valid) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reach_pixel2", 64'(wa_q.size() - wb), 64'(2));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", 64'({busy, done, rd_en, wr_valid, patch_valid}), 64'(0));
        check("t6_rst_data", 64'({rd_addr, wr_addr, wr_data}), 64'(0));
        @(negedge clk);
        check("t6_rst_patch", 64'(|patch_flat), 64'(0));
        check("t6_no_done", 64'(done_cnt - db), 64'(0));
        rst_n = 1'b1;
        fill_rand(16);
        run_frame("t6_new_frame", 4, 4, 0, 1'b0);

        // Empty frame: straight to done with no traffic
`ifdef CONV_ZERO_PAD_EN
        ew = 0;
`else
        ew = 2;
`endif
        rb = rd_q.size();
        wb = wa_q.size();
        db = done_cnt;
        pulse_start(ew, 4);
        check("empty_busy", 64'({busy, done}), 64'(2));
        @(negedge clk);
        check("empty_done", 64'({busy, done}), 64'(1));
        repeat (3) @(negedge clk);
        check("empty_reads", 64'(rd_q.size() - rb), 64'(0));
        check("empty_writes", 64'(wa_q.size() - wb), 64'(0));
        check("empty_one_done", 64'(done_cnt - db), 64'(1));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
